priority_in_service: RTL and testbench

- Stage directly downstream of the interrupt request register in the 8259 datapath.
- Resolves priority among unmasked pending requests against the in-service register (ISR) and drives the INT output.
- Sequences the two-pulse INTA acknowledge, producing freeze/clear strobes back to the request register and the interrupt vector for the data bus.
- Handles automatic, non-specific and specific EOI, with optional rotate-on-EOI.

---
 rtl/priority_in_service_if.sv | 33 +++
 rtl/priority_in_service.sv | 144 ++++++++++++++
 tb/tb_priority_in_service.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/priority_in_service_if.sv
// Signal bundle between the 8259 priority/in-service stage and its neighbours:
// request register, mask, CPU acknowledge and data-bus vector.
interface priority_in_service_if;
  logic [7:0] interrupt_req_register;
  logic [7:0] interrupt_mask;
  logic       inta;
  logic [4:0] vector_base;
  logic       auto_eoi;
  logic       rotate_on_eoi;
  logic       nonspecific_eoi;
  logic       specific_eoi;
  logic [2:0] eoi_level;
  logic       freeze;
  logic [7:0] clear_interrupt_req;
  logic       int_out;
  logic [7:0] in_service_register;
  logic [7:0] vector_out;
  logic       vector_out_en;

  modport master (
    output interrupt_req_register, interrupt_mask, inta, vector_base, auto_eoi,
           rotate_on_eoi, nonspecific_eoi, specific_eoi, eoi_level,
    input  freeze, clear_interrupt_req, int_out, in_service_register, vector_out,
           vector_out_en
  );

  modport slave (
    input  interrupt_req_register, interrupt_mask, inta, vector_base, auto_eoi,
           rotate_on_eoi, nonspecific_eoi, specific_eoi, eoi_level,
    output freeze, clear_interrupt_req, int_out, in_service_register, vector_out,
           vector_out_en
  );
endinterface

// File: rtl/priority_in_service.sv
// 8259 priority resolver and in-service register: rotating priority, fully nested
// qualification, two-pulse INTA sequencing and EOI handling.
module priority_in_service #(
  parameter int unsigned NUM_IR = 8
) (
  input logic                  clk,
  input logic                  reset,
  priority_in_service_if.slave pis
);

  localparam int unsigned LvlW = $clog2(NUM_IR);
  localparam int unsigned PosW = LvlW + 1;

  typedef enum logic [1:0] {StIdle, StAck1, StWait2, StAck2} state_e;

  state_e              state_q, state_d;
  logic                inta_q;
  logic [NUM_IR-1:0]   isr_q, isr_d;
  logic [LvlW-1:0]     lp_q, lp_d;
  logic [LvlW-1:0]     level_q, level_d;
  logic [NUM_IR-1:0]   clear_q, clear_d;
  logic                int_q, int_d;
  logic [7:0]          vector_q, vector_d;

  // Position of the first set bit in the rotated order (0 = highest priority);
  // NUM_IR means no bit set.
  function automatic logic [PosW-1:0] first_rot(logic [NUM_IR-1:0] v, logic [LvlW-1:0] lp);
    logic [2*NUM_IR-1:0] dbl;
    logic [PosW-1:0]     pos;
    dbl = {v, v} >> ({1'b0, lp} + 1'b1);
    pos = PosW'(NUM_IR);
    for (int i = NUM_IR - 1; i >= 0; i--) begin
      if (dbl[i]) pos = PosW'(i);
    end
    return pos;
  endfunction

  logic              inta_rise, inta_fall;
  logic [NUM_IR-1:0] req;
  logic [PosW-1:0]   cand_pos, isr_pos;
  logic [LvlW-1:0]   cand_lvl, isr_lvl;
  logic              qualify;
  logic              ack_take, vec_load, ack_done;
  logic              eoi_valid;
  logic [LvlW-1:0]   eoi_lvl;
  logic [NUM_IR-1:0] ack_set, auto_clr, eoi_clr;

  assign inta_rise = pis.inta & ~inta_q;
  assign inta_fall = ~pis.inta & inta_q;
  assign req       = pis.interrupt_req_register & ~pis.interrupt_mask;
  assign cand_pos  = first_rot(req, lp_q);
  assign isr_pos   = first_rot(isr_q, lp_q);
  assign cand_lvl  = cand_pos[LvlW-1:0] + lp_q + LvlW'(1);
  assign isr_lvl   = isr_pos[LvlW-1:0] + lp_q + LvlW'(1);
  // An empty ISR reports position NUM_IR, so any real candidate beats it.
  assign qualify   = ~cand_pos[LvlW] & (cand_pos < isr_pos);

  assign ack_take = (state_q == StIdle) & inta_rise;
  assign vec_load = (state_q == StWait2) & inta_rise;
  assign ack_done = (state_q == StAck2) & inta_fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (inta_rise) state_d = StAck1;
      StAck1:  if (inta_fall) state_d = StWait2;
      StWait2: if (inta_rise) state_d = StAck2;
      StAck2:  if (inta_fall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pis.freeze        = (state_q != StIdle);
    pis.vector_out_en = (state_q == StAck2);
  end

  always_comb begin
    level_d  = level_q;
    ack_set  = '0;
    auto_clr = '0;
    vector_d = vector_q;
    lp_d     = lp_q;
    if (ack_take) begin
      // No qualified request on the first pulse: spurious IR7, nothing set.
      level_d = qualify ? cand_lvl : LvlW'(NUM_IR - 1);
      if (qualify) ack_set = NUM_IR'(1) << cand_lvl;
    end
    if (vec_load) vector_d = {pis.vector_base, level_q};
    if (ack_done && pis.auto_eoi) begin
      auto_clr = NUM_IR'(1) << level_q;
      if (pis.rotate_on_eoi) lp_d = level_q;
    end

    eoi_valid = 1'b0;
    eoi_lvl   = pis.eoi_level;
    if (pis.specific_eoi) begin
      eoi_valid = 1'b1;
    end else if (pis.nonspecific_eoi && !isr_pos[LvlW]) begin
      eoi_valid = 1'b1;
      eoi_lvl   = isr_lvl;
    end
    eoi_clr = eoi_valid ? (NUM_IR'(1) << eoi_lvl) : '0;
    if (eoi_valid && pis.rotate_on_eoi) lp_d = eoi_lvl;

    isr_d   = (isr_q & ~(eoi_clr | auto_clr)) | ack_set;
    clear_d = ack_set;
    int_d   = qualify & (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inta_q   <= 1'b0;
      isr_q    <= '0;
      lp_q     <= LvlW'(NUM_IR - 1);
      level_q  <= '0;
      clear_q  <= '0;
      int_q    <= 1'b0;
      vector_q <= '0;
    end else begin
      inta_q   <= pis.inta;
      isr_q    <= isr_d;
      lp_q     <= lp_d;
      level_q  <= level_d;
      clear_q  <= clear_d;
      int_q    <= int_d;
      vector_q <= vector_d;
    end
  end

  assign pis.in_service_register = isr_q;
  assign pis.clear_interrupt_req = clear_q;
  assign pis.int_out             = int_q;
  assign pis.vector_out          = vector_q;

endmodule

// File: tb/tb_priority_in_service.sv
// Bench for priority_in_service: a rank-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_priority_in_service;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  priority_in_service_if bus();
  priority_in_service #(.NUM_IR(8)) dut (.clk(clk), .reset(reset), .pis(bus));

  int n_vec = 0;
  int n_err = 0;
  bit check_en = 1'b0;

  logic [7:0] m_isr = 8'h00, m_clear = 8'h00, m_vec = 8'h00;
  int m_lp = 7, m_phase = 0, m_level = 7;
  bit m_int = 1'b0, m_inta_prev = 1'b0;

  // 0 = highest priority, 7 = lowest (the lowest_priority level itself).
  function automatic int rank(int lvl, int lp);
    return (lvl - lp + 15) % 8;
  endfunction

  function automatic int top_of(logic [7:0] v, int lp);
    int best = -1;
    for (int l = 0; l < 8; l++)
      if (v[l] && (best < 0 || rank(l, lp) < rank(best, lp))) best = l;
    return best;
  endfunction

  always @(posedge clk) begin
    int cand, top, nph, nlp;
    bit qual, rise, fall;
    logic [7:0] req, ack_set, clr;
    if (reset) begin
      m_isr = 0; m_clear = 0; m_vec = 0; m_lp = 7; m_phase = 0; m_level = 7;
      m_int = 0; m_inta_prev = 0;
    end else begin
      rise = bus.inta && !m_inta_prev;
      fall = !bus.inta && m_inta_prev;
      req  = bus.interrupt_req_register & ~bus.interrupt_mask;
      cand = top_of(req, m_lp);
      top  = top_of(m_isr, m_lp);
      qual = (cand >= 0) && (top < 0 || rank(cand, m_lp) < rank(top, m_lp));
      ack_set = 0; clr = 0; nph = m_phase; nlp = m_lp;
      case (m_phase)
        0: if (rise) begin
             m_level = qual ? cand : 7;
             if (qual) ack_set = 8'(1 << cand);
             nph = 1;
           end
        1: if (fall) nph = 2;
        2: if (rise) begin m_vec = {bus.vector_base, 3'(m_level)}; nph = 3; end
        default: if (fall) begin
             nph = 0;
             if (bus.auto_eoi) begin
               clr = 8'(1 << m_level);
               if (bus.rotate_on_eoi) nlp = m_level;
             end
           end
      endcase
      if (bus.specific_eoi) begin
        clr = clr | 8'(1 << bus.eoi_level);
        if (bus.rotate_on_eoi) nlp = int'(bus.eoi_level);
      end else if (bus.nonspecific_eoi && top >= 0) begin
        clr = clr | 8'(1 << top);
        if (bus.rotate_on_eoi) nlp = top;
      end
      m_int = qual && (nph == 0);
      m_clear = ack_set;
      m_isr = (m_isr & ~clr) | ack_set;
      m_lp = nlp; m_phase = nph; m_inta_prev = bus.inta;
    end
  end

  task automatic cmp(string name, logic [7:0] act, logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      cmp("int_out", {7'b0, bus.int_out}, {7'b0, m_int});
      cmp("isr", bus.in_service_register, m_isr);
      cmp("clear_req", bus.clear_interrupt_req, m_clear);
      cmp("freeze", {7'b0, bus.freeze}, {7'b0, m_phase != 0});
      cmp("vec_en", {7'b0, bus.vector_out_en}, {7'b0, m_phase == 3});
      cmp("vector_out", bus.vector_out, m_vec);
    end
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; step(1); reset = 1'b0;
  endtask

  task automatic ack_full();
    bus.inta = 1'b1; step(2); bus.inta = 1'b0; step(2);
    bus.inta = 1'b1; step(2); bus.inta = 1'b0; step(2);
  endtask

  task automatic eoi(bit ns, bit sp, logic [2:0] lvl);
    bus.nonspecific_eoi = ns; bus.specific_eoi = sp; bus.eoi_level = lvl;
    step(1);
    bus.nonspecific_eoi = 1'b0; bus.specific_eoi = 1'b0;
  endtask

  initial begin
    bus.interrupt_req_register = 8'h00; bus.interrupt_mask = 8'h00; bus.inta = 1'b0;
    bus.vector_base = 5'b0; bus.auto_eoi = 1'b0; bus.rotate_on_eoi = 1'b0;
    bus.nonspecific_eoi = 1'b0; bus.specific_eoi = 1'b0; bus.eoi_level = 3'd0;
    step(1);
    reset = 1'b0;
    check_en = 1'b1;

    // Basic acknowledge of IR2 out of 8'h24.
    do_reset();
    cmp("rst_int", {7'b0, bus.int_out}, 8'h00);
    cmp("rst_isr", bus.in_service_register, 8'h00);
    cmp("rst_freeze", {7'b0, bus.freeze}, 8'h00);
    cmp("rst_vec", bus.vector_out, 8'h00);
    cmp("model_rst_lp", 8'(m_lp), 8'd7);
    bus.interrupt_req_register = 8'h24; step(1);
    cmp("s1_int", {7'b0, bus.int_out}, 8'h01);
    bus.inta = 1'b1; step(1);
    cmp("s1_isr", bus.in_service_register, 8'h04);
    cmp("s1_clear", bus.clear_interrupt_req, 8'h04);
    cmp("s1_freeze", {7'b0, bus.freeze}, 8'h01);
    bus.interrupt_mask = 8'hFF; step(1);
    cmp("s1_clear_1cyc", bus.clear_interrupt_req, 8'h00);
    bus.inta = 1'b0; step(1);
    bus.vector_base = 5'b01000; bus.inta = 1'b1; step(1);
    cmp("s1_vec", bus.vector_out, 8'h42);
    cmp("s1_vec_en", {7'b0, bus.vector_out_en}, 8'h01);
    bus.inta = 1'b0; step(1);
    cmp("s1_freeze_off", {7'b0, bus.freeze}, 8'h00);
    cmp("s1_isr_hold", bus.in_service_register, 8'h04);

    // Fully nested qualification against ISR=8'h04.
    bus.interrupt_mask = 8'h00; bus.interrupt_req_register = 8'h02; step(1);
    cmp("nest_ir1", {7'b0, bus.int_out}, 8'h01);
    bus.interrupt_req_register = 8'h40; step(1);
    cmp("nest_ir6", {7'b0, bus.int_out}, 8'h00);
    bus.interrupt_req_register = 8'h04; step(1);
    cmp("nest_same", {7'b0, bus.int_out}, 8'h00);

    // Spurious acknowledge.
    do_reset();
    bus.interrupt_req_register = 8'h01; step(1);
    cmp("sp_int", {7'b0, bus.int_out}, 8'h01);
    bus.interrupt_req_register = 8'h00; bus.vector_base = 5'b10101; bus.inta = 1'b1; step(1);
    cmp("sp_isr", bus.in_service_register, 8'h00);
    cmp("sp_clear", bus.clear_interrupt_req, 8'h00);
    step(1); bus.inta = 1'b0; step(2); bus.inta = 1'b1; step(1);
    cmp("sp_vec", bus.vector_out, 8'hAF);
    step(1); bus.inta = 1'b0; step(2);

    // Auto-EOI with rotation.
    do_reset();
    bus.auto_eoi = 1'b1; bus.rotate_on_eoi = 1'b1;
    bus.interrupt_req_register = 8'h08; step(1);
    bus.inta = 1'b1; step(2); bus.interrupt_req_register = 8'h00;
    bus.inta = 1'b0; step(2); bus.inta = 1'b1; step(2); bus.inta = 1'b0; step(1);
    cmp("ae_isr", bus.in_service_register, 8'h00);
    cmp("model_ae_lp", 8'(m_lp), 8'd3);
    step(1);
    bus.interrupt_req_register = 8'h11; step(1);
    cmp("ae_int", {7'b0, bus.int_out}, 8'h01);
    bus.inta = 1'b1; step(1);
    cmp("ae_ir4_first", bus.in_service_register, 8'h10);
    step(1); bus.inta = 1'b0; step(2); bus.inta = 1'b1; step(2); bus.inta = 1'b0; step(2);
    cmp("ae_isr2", bus.in_service_register, 8'h00);
    bus.auto_eoi = 1'b0; bus.rotate_on_eoi = 1'b0; bus.interrupt_req_register = 8'h00;

    // EOI handling.
    do_reset();
    bus.interrupt_req_register = 8'h08; step(1); ack_full();
    bus.interrupt_req_register = 8'h02; step(1); ack_full();
    bus.interrupt_req_register = 8'h00;
    cmp("eoi_isr0a", bus.in_service_register, 8'h0A);
    eoi(1'b1, 1'b0, 3'd0);
    cmp("eoi_ns", bus.in_service_register, 8'h08);
    eoi(1'b0, 1'b1, 3'd3);
    cmp("eoi_sp", bus.in_service_register, 8'h00);
    bus.interrupt_req_register = 8'h08; step(1); ack_full();
    bus.interrupt_req_register = 8'h02; step(1); ack_full();
    bus.interrupt_req_register = 8'h00;
    eoi(1'b1, 1'b1, 3'd1);
    cmp("eoi_both1", bus.in_service_register, 8'h08);
    bus.interrupt_req_register = 8'h02; step(1); ack_full();
    bus.interrupt_req_register = 8'h00;
    bus.rotate_on_eoi = 1'b1;
    eoi(1'b1, 1'b1, 3'd3);
    bus.rotate_on_eoi = 1'b0;
    cmp("eoi_both3", bus.in_service_register, 8'h02);
    cmp("model_eoi_lp", 8'(m_lp), 8'd3);
    bus.interrupt_req_register = 8'h10; step(1);
    cmp("eoi_rot_int", {7'b0, bus.int_out}, 8'h01);
    bus.interrupt_req_register = 8'h00;

    // Reset while waiting for the second pulse.
    do_reset();
    bus.interrupt_req_register = 8'h01; step(1);
    bus.inta = 1'b1; step(2); bus.inta = 1'b0; step(2);
    cmp("w2_freeze", {7'b0, bus.freeze}, 8'h01);
    reset = 1'b1; step(1); reset = 1'b0;
    cmp("rw_freeze", {7'b0, bus.freeze}, 8'h00);
    cmp("rw_isr", bus.in_service_register, 8'h00);
    cmp("rw_int", {7'b0, bus.int_out}, 8'h00);
    cmp("rw_vec_en", {7'b0, bus.vector_out_en}, 8'h00);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
